pipeline_step_ctrl: RTL and testbench
=====================================

# pipeline_step_ctrl

Run-control block for the MIPS pipeline. It gates the pipeline's stage enables so the core can free-run, execute exactly N fetch cycles, or stop on a breakpoint or HALT instruction. On every stop it drains the in-flight instructions cleanly and counts enabled cycles. It sits between the test/debug host and the `Pipeline` top, replacing hand-toggled clocking with clock-enable control on a free-running `clk`.

## Interface
- `STAGES`, 5: pipeline depth; drain length is `STAGES-1` (legal ≥1).
- `CNT_W`, 16: width of step count.
- `CYC_W`, 32: width of cycle counter.
- `PC_W`, 32: program-counter width.
- `NUM_BP`, 2: number of breakpoint entries (≥1); `BP_W = max(1,$clog2(NUM_BP))`.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when `cmd_valid & cmd_ready`.
- `cmd_op`  in  2  00 RUN, 01 STEP, 10 HALT, 11 CLR_CNT.
- `cmd_count`  in  CNT_W  fetch cycles for STEP.
- `pc`  in  PC_W  current fetch PC from IF stage.
- `halt_in`  in  1  pipeline decoded a HALT instruction this cycle.
- `bp_wr`  in  1  write breakpoint entry.
- `bp_idx`  in  BP_W  entry index.
- `bp_addr`  in  PC_W  breakpoint PC.
- `bp_en`  in  1  entry enable.
- `fetch_en`  out  1  IF/PC update enable.
- `pipe_en`  out  1  enable for all other stage registers.
- `done`  out  1  one-cycle pulse on return to HALTED.
- `halt_cause`  out  2  00 NONE, 01 CMD, 10 BP, 11 INSN; STEP exhaustion reports NONE.
- `cycle_count`  out  CYC_W  cycles with `pipe_en=1`, wraps.

## Operation
- States: HALTED, RUN, STEP, DRAIN. Outputs decode from registered state (Moore).
  - HALTED: `fetch_en=0`, `pipe_en=0`.
  - RUN/STEP: `fetch_en=1`, `pipe_en=1`.
  - DRAIN: `fetch_en=0`, `pipe_en=1`.
- `cmd_ready=1` in every state except DRAIN.
- HALTED transitions:
  - RUN → RUN.
  - STEP with count N>0 → STEP, `remaining=N`.
  - STEP with count 0, and HALT: accepted no-ops.
- RUN/STEP: RUN and STEP commands are accepted and dropped. HALT ends the run.
- Stop condition, evaluated each RUN/STEP cycle:
  - `halt_in`, else breakpoint match, else HALT command, else (STEP only) `remaining==1`.
  - Cause latched with the same priority: INSN > BP > CMD > NONE.
  - Next state is DRAIN, or HALTED directly if `STAGES==1`.
- STEP decrements `remaining` each cycle.
- Breakpoint match: any enabled entry with `bp_addr==pc`. Suppressed on the first RUN/STEP cycle after leaving HALTED, so the core can resume off a breakpoint.
- DRAIN runs `STAGES-1` cycles, then HALTED with `done` pulsed in the first HALTED cycle.
- `halt_cause` holds until the next RUN/STEP is accepted, then clears to NONE.
- CLR_CNT clears `cycle_count` in any state where it is accepted. If `pipe_en=1` that cycle, the counter ends at 0, not 1 (clear wins).
- `bp_wr` writes the entry synchronously, in any state; the entry is effective the next cycle.
- Reset (any time, including mid-DRAIN) forces:
  - HALTED;
  - `fetch_en=pipe_en=done=0`, `cmd_ready=1`;
  - `halt_cause=NONE`, `cycle_count=0`;
  - all `bp_en=0`.
  - No drain and no `done` follow reset.

## Timing
- Command accepted at cycle T: new state at T+1, so `fetch_en` first rises at T+1.
- STEP N: `fetch_en` high T+1..T+N; DRAIN T+N+1..T+N+STAGES-1; `done` at T+N+STAGES.
- Stop detected at cycle T in RUN: that cycle still fetches; `fetch_en=0` from T+1; `done` at T+STAGES.
- `done` never coincides with `fetch_en=1`.
- A command accepted in the `done` cycle starts normally at the next cycle.

## Structure
- Package `pipeline_ctrl_pkg`: `cmd_op` encodings, state enum, `halt_cause` encodings.
- Sub-module `bp_match`: breakpoint table, per-entry comparator, OR-reduced hit.

## Test plan
- STEP `cmd_count=3`, STAGES=5 → `fetch_en` high 3 cycles, `pipe_en` 7 cycles, `done` 8 cycles after accept, `halt_cause=NONE`, `cycle_count=7`.
- BP0=0x40 enabled, RUN with `pc` +4 per cycle from 0 → stop at pc=0x40 (17th run cycle), cause BP. Then STEP 1 at pc=0x40 → exactly 1 fetch, no re-trap.
- `halt_in` and BP hit in the same cycle → cause INSN, single drain.
- HALT during RUN → cause CMD, `cmd_ready=0` through DRAIN. CLR_CNT held valid during drain is accepted in the `done` cycle and zeroes `cycle_count`.
- `rst_n` low mid-DRAIN → all outputs at reset values immediately, no `done` after release.
- CYC_W=4: RUN 20 cycles → `cycle_count` wraps to 4 at the end of the 20th run cycle, before drain.

Source files
------------

// File: rtl/pipeline_step_ctrl_pkg.sv
// Shared encodings for the pipeline run-control block.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_RUN  = 2'b00,
    OP_STEP = 2'b01,
    OP_HALT = 2'b10,
    OP_CLR  = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_HALTED = 2'b00,
    ST_RUN    = 2'b01,
    ST_STEP   = 2'b10,
    ST_DRAIN  = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'b00,
    CAUSE_CMD  = 2'b01,
    CAUSE_BP   = 2'b10,
    CAUSE_INSN = 2'b11
  } halt_cause_e;

  // Index width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pipeline_step_ctrl_if.sv
// Host/pipeline-facing signal bundle for the run-control block.
interface pipeline_step_ctrl_if
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned CYC_W  = 32,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned NUM_BP = 2
);
  localparam int unsigned BP_W = clog2_min1(NUM_BP);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_count;
  logic [PC_W-1:0]  pc;
  logic             halt_in;
  logic             bp_wr;
  logic [BP_W-1:0]  bp_idx;
  logic [PC_W-1:0]  bp_addr;
  logic             bp_en;
  logic             fetch_en;
  logic             pipe_en;
  logic             done;
  logic [1:0]       halt_cause;
  logic [CYC_W-1:0] cycle_count;

  modport master (
    output cmd_valid, cmd_op, cmd_count, pc, halt_in, bp_wr, bp_idx, bp_addr, bp_en,
    input  cmd_ready, fetch_en, pipe_en, done, halt_cause, cycle_count
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_count, pc, halt_in, bp_wr, bp_idx, bp_addr, bp_en,
    output cmd_ready, fetch_en, pipe_en, done, halt_cause, cycle_count
  );
endinterface

// File: rtl/pipeline_step_ctrl_bp_match.sv
// Breakpoint table with per-entry PC comparators and an OR-reduced hit.
module bp_match
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned NUM_BP = 2,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned BP_W   = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_i,
  input  logic [BP_W-1:0] idx_i,
  input  logic [PC_W-1:0] addr_i,
  input  logic            en_i,
  input  logic [PC_W-1:0] pc_i,
  output logic            hit_c_o
);

  logic [PC_W-1:0]   addr_q [NUM_BP];
  logic [NUM_BP-1:0] en_q;

  // Table write; indices beyond NUM_BP are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q <= '0;
      for (int i = 0; i < int'(NUM_BP); i++) addr_q[i] <= '0;
    end else if (wr_i) begin
      for (int i = 0; i < int'(NUM_BP); i++) begin
        if (idx_i == BP_W'(i)) begin
          addr_q[i] <= addr_i;
          en_q[i]   <= en_i;
        end
      end
    end
  end

  // Any enabled entry matching the current fetch PC.
  always_comb begin
    hit_c_o = 1'b0;
    for (int i = 0; i < int'(NUM_BP); i++) begin
      if (en_q[i] && (addr_q[i] == pc_i)) hit_c_o = 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_step_ctrl.sv
// Run/step/halt control for the pipeline: gates stage enables, drains on stop,
// counts enabled cycles.
module pipeline_step_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned STAGES = 5,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned CYC_W  = 32,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned NUM_BP = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  pipeline_step_ctrl_if.slave bus
);

  localparam int unsigned BP_W = clog2_min1(NUM_BP);
  localparam int unsigned DR_W = clog2_min1(STAGES);
  localparam logic [DR_W-1:0] DRAIN_LEN = DR_W'(STAGES - 1);
  localparam state_e STOP_ST = (STAGES > 1) ? ST_DRAIN : ST_HALTED;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [DR_W-1:0]  drain_q, drain_d;
  logic             first_q, first_d;
  halt_cause_e      cause_q, cause_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic             fetch_en_q, pipe_en_q, ready_q, done_q;

  logic    bp_hit_c;
  logic    accept_c;
  logic    stop_c;
  cmd_op_e op_c;

  bp_match #(
    .NUM_BP (NUM_BP),
    .PC_W   (PC_W),
    .BP_W   (BP_W)
  ) u_bp_match (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_i    (bus.bp_wr),
    .idx_i   (bus.bp_idx),
    .addr_i  (bus.bp_addr),
    .en_i    (bus.bp_en),
    .pc_i    (bus.pc),
    .hit_c_o (bp_hit_c)
  );

  // Next-state, stop detection, step/drain counters and cycle counter.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    drain_d     = drain_q;
    first_d     = 1'b0;
    cause_d     = cause_q;
    cyc_d       = cyc_q;
    op_c        = cmd_op_e'(bus.cmd_op);
    accept_c    = bus.cmd_valid & ready_q;
    stop_c      = 1'b0;

    if (pipe_en_q) cyc_d = cyc_q + CYC_W'(1);
    if (accept_c && (op_c == OP_CLR)) cyc_d = '0;

    unique case (state_q)
      ST_HALTED: begin
        if (accept_c && (op_c == OP_RUN)) begin
          state_d = ST_RUN;
          first_d = 1'b1;
          cause_d = CAUSE_NONE;
        end else if (accept_c && (op_c == OP_STEP) && (bus.cmd_count != '0)) begin
          state_d     = ST_STEP;
          remaining_d = bus.cmd_count;
          first_d     = 1'b1;
          cause_d     = CAUSE_NONE;
        end
      end
      ST_RUN, ST_STEP: begin
        if (state_q == ST_STEP) remaining_d = remaining_q - CNT_W'(1);
        stop_c = bus.halt_in
               | (bp_hit_c & ~first_q)
               | (accept_c & (op_c == OP_HALT))
               | ((state_q == ST_STEP) & (remaining_q == CNT_W'(1)));
        if (stop_c) begin
          state_d = STOP_ST;
          drain_d = DRAIN_LEN;
          if (bus.halt_in)                         cause_d = CAUSE_INSN;
          else if (bp_hit_c && !first_q)           cause_d = CAUSE_BP;
          else if (accept_c && (op_c == OP_HALT))  cause_d = CAUSE_CMD;
          else                                     cause_d = CAUSE_NONE;
        end
      end
      ST_DRAIN: begin
        if (drain_q <= DR_W'(1)) state_d = ST_HALTED;
        else                     drain_d = drain_q - DR_W'(1);
      end
      default: state_d = ST_HALTED;
    endcase
  end

  // State register plus registered Moore outputs decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_HALTED;
      remaining_q <= '0;
      drain_q     <= '0;
      first_q     <= 1'b0;
      cause_q     <= CAUSE_NONE;
      cyc_q       <= '0;
      fetch_en_q  <= 1'b0;
      pipe_en_q   <= 1'b0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      drain_q     <= drain_d;
      first_q     <= first_d;
      cause_q     <= cause_d;
      cyc_q       <= cyc_d;
      fetch_en_q  <= (state_d == ST_RUN) || (state_d == ST_STEP);
      pipe_en_q   <= (state_d != ST_HALTED);
      ready_q     <= (state_d != ST_DRAIN);
      done_q      <= (state_q != ST_HALTED) && (state_d == ST_HALTED);
    end
  end

  assign bus.cmd_ready   = ready_q;
  assign bus.fetch_en    = fetch_en_q;
  assign bus.pipe_en     = pipe_en_q;
  assign bus.done        = done_q;
  assign bus.halt_cause  = cause_q;
  assign bus.cycle_count = cyc_q;

endmodule

// File: tb/tb_pipeline_step_ctrl.sv
// Scoreboard bench for pipeline_step_ctrl: stimulus pushes expected run results,
// a negedge monitor checks them on every done pulse.
module tb_pipeline_step_ctrl;

  typedef struct {
    int         t0;
    int         lat;
    logic [1:0] cause;
    int         cnt;
    int         fetches;
    int         pipes;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc_n = 0;
  int   n_pass = 0;
  int   n_tot = 0;
  exp_t exp_q [$];

  logic [31:0] pc_r;
  logic        pc_ld;
  logic [31:0] pc_ld_v;
  logic        insn_arm;

  int fetch_n, pipe_n;

  pipeline_step_ctrl_if bus ();
  pipeline_step_ctrl_if #(.CYC_W(4)) v4 ();

  pipeline_step_ctrl u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  pipeline_step_ctrl #(.CYC_W(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(v4));

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Simple IF-stage PC model: advances on fetch, loadable by the host.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)        pc_r <= '0;
    else if (pc_ld)    pc_r <= pc_ld_v;
    else if (bus.fetch_en) pc_r <= pc_r + 32'd4;
  end

  assign bus.pc      = pc_r;
  assign bus.halt_in = insn_arm && (pc_r == 32'h40);

  assign v4.cmd_valid = bus.cmd_valid;
  assign v4.cmd_op    = bus.cmd_op;
  assign v4.cmd_count = bus.cmd_count;
  assign v4.pc        = bus.pc;
  assign v4.halt_in   = bus.halt_in;
  assign v4.bp_wr     = bus.bp_wr;
  assign v4.bp_idx    = bus.bp_idx;
  assign v4.bp_addr   = bus.bp_addr;
  assign v4.bp_en     = bus.bp_en;

  function automatic void chk(input string name, input longint act, input longint exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc_n);
  endfunction

  // Monitor: pop and compare on every done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      fetch_n = 0;
      pipe_n  = 0;
    end else begin
      if (bus.done) begin
        chk("done_with_fetch", longint'(bus.fetch_en), 0);
        chk("done_cmd_ready", longint'(bus.cmd_ready), 1);
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("halt_cause", longint'(bus.halt_cause), longint'(e.cause));
          chk("cycle_count", longint'(bus.cycle_count), longint'(e.cnt));
          chk("fetch_cycles", fetch_n, e.fetches);
          chk("pipe_cycles", pipe_n, e.pipes);
          chk("done_latency", cyc_n - e.t0, e.lat);
        end
        fetch_n = 0;
        pipe_n  = 0;
      end
      if (bus.fetch_en) fetch_n++;
      if (bus.pipe_en)  pipe_n++;
    end
  end

  task automatic send(input logic [1:0] op, input logic [15:0] cnt, input int at_cyc,
                      output int acc);
    logic got = 1'b0;
    acc = -1;
    do @(negedge clk); while (cyc_n < at_cyc);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_count = cnt;
    for (int i = 0; i < 100; i++) begin
      if (bus.cmd_ready) begin
        acc = cyc_n;
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic push(input int t0, input int lat, input logic [1:0] cause, input int cnt,
                      input int f, input int p);
    exp_t e;
    e.t0 = t0; e.lat = lat; e.cause = cause; e.cnt = cnt; e.fetches = f; e.pipes = p;
    exp_q.push_back(e);
  endtask

  task automatic wait_sb();
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      chk("scoreboard_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic set_pc(input logic [31:0] v);
    @(negedge clk);
    pc_ld = 1'b1;
    pc_ld_v = v;
    @(negedge clk);
    pc_ld = 1'b0;
  endtask

  task automatic clr_cnt();
    int a;
    send(2'b11, 16'd0, 0, a);
  endtask

  initial begin
    int a, h, t;
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_count = '0;
    bus.bp_wr = 1'b0; bus.bp_idx = '0; bus.bp_addr = '0; bus.bp_en = 1'b0;
    pc_ld = 1'b0; pc_ld_v = '0; insn_arm = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_fetch_en", longint'(bus.fetch_en), 0);
    chk("rst_pipe_en", longint'(bus.pipe_en), 0);
    chk("rst_done", longint'(bus.done), 0);
    chk("rst_cmd_ready", longint'(bus.cmd_ready), 1);
    chk("rst_halt_cause", longint'(bus.halt_cause), 0);
    chk("rst_cycle_count", longint'(bus.cycle_count), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // BP0 = 0x40, RUN from pc 0: trap on 17th run cycle.
    bus.bp_wr = 1'b1; bus.bp_idx = 1'b0; bus.bp_addr = 32'h40; bus.bp_en = 1'b1;
    @(negedge clk);
    bus.bp_wr = 1'b0;
    send(2'b00, 16'd0, 0, a);
    push(a, 22, 2'b10, 21, 17, 21);
    wait_sb();

    // Resume off the breakpoint with STEP 1.
    clr_cnt();
    set_pc(32'h40);
    send(2'b01, 16'd1, 0, a);
    push(a, 6, 2'b00, 5, 1, 5);
    wait_sb();

    // STEP 3.
    clr_cnt();
    set_pc(32'h80);
    send(2'b01, 16'd3, 0, a);
    push(a, 8, 2'b00, 7, 3, 7);
    wait_sb();

    // STEP 0 is a no-op: no done, nothing counts.
    send(2'b01, 16'd0, 0, a);
    repeat (10) @(negedge clk);
    chk("step0_noop_pipe", longint'(bus.pipe_en), 0);

    // HALT instruction and breakpoint in the same cycle.
    clr_cnt();
    set_pc(32'h30);
    insn_arm = 1'b1;
    send(2'b00, 16'd0, 0, a);
    push(a, 10, 2'b11, 9, 5, 9);
    wait_sb();
    insn_arm = 1'b0;

    // HALT command during RUN, CLR_CNT held through drain.
    clr_cnt();
    set_pc(32'h100);
    send(2'b00, 16'd0, 0, a);
    push(a, 8, 2'b01, 7, 3, 7);
    send(2'b10, 16'd0, a + 3, h);
    chk("halt_accept_cycle", h, a + 3);
    send(2'b11, 16'd0, 0, t);
    chk("clr_in_done_cycle", t, h + 5);
    @(negedge clk);
    chk("clr_after_drain", longint'(bus.cycle_count), 0);
    wait_sb();

    // Reset in the middle of DRAIN.
    set_pc(32'h200);
    send(2'b01, 16'd2, 0, a);
    do @(negedge clk); while (cyc_n < a + 4);
    chk("pre_rst_in_drain", longint'(bus.cmd_ready), 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_fetch_en", longint'(bus.fetch_en), 0);
    chk("mid_rst_pipe_en", longint'(bus.pipe_en), 0);
    chk("mid_rst_cmd_ready", longint'(bus.cmd_ready), 1);
    chk("mid_rst_halt_cause", longint'(bus.halt_cause), 0);
    chk("mid_rst_cycle_count", longint'(bus.cycle_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);

    // Breakpoints cleared by reset; 4-bit counter wraps after 20 run cycles.
    send(2'b00, 16'd0, 0, a);
    push(a, 25, 2'b01, 24, 20, 24);
    send(2'b10, 16'd0, a + 20, h);
    @(negedge clk);
    chk("wrap_cnt4", longint'(v4.cycle_count), 4);
    chk("wrap_cnt32", longint'(bus.cycle_count), 20);
    wait_sb();
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
